// File: rtl/remote_comm_if.sv
// Host-side handshake of the ground-station command link: request, payload,
// and the status/response pulses coming back from the transmitter/receiver.
interface remote_comm_if;
  logic        snd_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        busy;
  logic        cmd_cmplt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        timeout;

  modport master (
    output snd_cmd, cmd, data,
    input  busy, cmd_cmplt, resp_rdy, resp, timeout
  );

  modport slave (
    input  snd_cmd, cmd, data,
    output busy, cmd_cmplt, resp_rdy, resp, timeout
  );
endinterface

// File: rtl/remote_comm.sv
// Ground-station end of the copter command link: sends cmd, data[15:8], data[7:0]
// as back-to-back UART 8N1 frames, then waits for a one-byte response or times out.
module remote_comm #(
  parameter int          BAUD_DIV     = 2604,
  parameter logic [25:0] RESP_TIMEOUT = 26'd50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  remote_comm_if.slave host,
  output logic         TX,
  input  logic         RX
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] BAUD_MID  = 12'(BAUD_DIV / 2 - 1);
  localparam logic [25:0] TMO_LAST  = RESP_TIMEOUT - 26'd1;

  typedef enum logic [2:0] {IDLE, TX_CMD, TX_DH, TX_DL, WAIT_RESP} state_t;
  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t      state, state_nxt;
  logic [7:0]  cmd_q, cmd_nxt;
  logic [15:0] data_q, data_nxt;
  logic        tx_q, tx_nxt;
  logic [3:0]  tx_bit, tx_bit_nxt;
  logic [11:0] tx_baud, tx_baud_nxt;
  logic [25:0] tmo_cnt, tmo_cnt_nxt;
  logic [7:0]  resp_q, resp_nxt;
  logic        cmplt_q, cmplt_nxt;
  logic        rdy_q, rdy_nxt;
  logic        tmo_q, tmo_nxt;
  logic [7:0]  cur_byte;

  rx_state_t   rx_state, rx_state_nxt;
  logic        rx_s1, rx_s2, rx_prev;
  logic [11:0] rx_baud, rx_baud_nxt;
  logic [3:0]  rx_bit, rx_bit_nxt;
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic        rx_good;

  // Frame bit idx of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic v;
    if (idx == 4'd0)
      v = 1'b0;
    else if (idx >= 4'd9)
      v = 1'b1;
    else
      v = b[3'(idx - 4'd1)];
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_HUNT;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_baud  <= rx_baud_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  // Receiver: start is confirmed mid-bit, later bits are sampled one bit period apart.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_baud_nxt  = rx_baud;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_good      = 1'b0;
    case (rx_state)
      RX_HUNT: begin
        if (rx_prev && !rx_s2) begin
          rx_state_nxt = RX_START;
          rx_baud_nxt  = '0;
        end
      end
      RX_START: begin
        if (rx_baud == BAUD_MID) begin
          rx_baud_nxt  = '0;
          rx_bit_nxt   = '0;
          rx_state_nxt = rx_s2 ? RX_HUNT : RX_DATA;
        end else begin
          rx_baud_nxt = rx_baud + 12'd1;
        end
      end
      RX_DATA: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_nxt  = '0;
          rx_shift_nxt = {rx_s2, rx_shift[7:1]};
          rx_bit_nxt   = rx_bit + 4'd1;
          if (rx_bit == 4'd7)
            rx_state_nxt = RX_STOP;
        end else begin
          rx_baud_nxt = rx_baud + 12'd1;
        end
      end
      RX_STOP: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_nxt  = '0;
          rx_good      = rx_s2;
          rx_state_nxt = RX_HUNT;
        end else begin
          rx_baud_nxt = rx_baud + 12'd1;
        end
      end
      default: rx_state_nxt = RX_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cmd_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      tx_bit  <= '0;
      tx_baud <= '0;
      tmo_cnt <= '0;
      resp_q  <= '0;
      cmplt_q <= 1'b0;
      rdy_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cmd_q   <= cmd_nxt;
      data_q  <= data_nxt;
      tx_q    <= tx_nxt;
      tx_bit  <= tx_bit_nxt;
      tx_baud <= tx_baud_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      resp_q  <= resp_nxt;
      cmplt_q <= cmplt_nxt;
      rdy_q   <= rdy_nxt;
      tmo_q   <= tmo_nxt;
    end
  end

  // TX line value is computed one cycle ahead so the pin comes straight from a flop.
  always_comb begin
    state_nxt   = state;
    cmd_nxt     = cmd_q;
    data_nxt    = data_q;
    tx_nxt      = tx_q;
    tx_bit_nxt  = tx_bit;
    tx_baud_nxt = tx_baud;
    tmo_cnt_nxt = tmo_cnt;
    resp_nxt    = resp_q;
    cmplt_nxt   = 1'b0;
    rdy_nxt     = 1'b0;
    tmo_nxt     = 1'b0;
    case (state)
      TX_DH:   cur_byte = data_q[15:8];
      TX_DL:   cur_byte = data_q[7:0];
      default: cur_byte = cmd_q;
    endcase
    case (state)
      IDLE: begin
        if (host.snd_cmd) begin
          cmd_nxt     = host.cmd;
          data_nxt    = host.data;
          state_nxt   = TX_CMD;
          tx_nxt      = 1'b0;
          tx_bit_nxt  = '0;
          tx_baud_nxt = '0;
        end
      end
      TX_CMD, TX_DH, TX_DL: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_nxt = '0;
          if (tx_bit == 4'd9) begin
            tx_bit_nxt = '0;
            if (state == TX_DL) begin
              state_nxt   = WAIT_RESP;
              tx_nxt      = 1'b1;
              cmplt_nxt   = 1'b1;
              tmo_cnt_nxt = '0;
            end else begin
              state_nxt = (state == TX_CMD) ? TX_DH : TX_DL;
              tx_nxt    = 1'b0;
            end
          end else begin
            tx_bit_nxt = tx_bit + 4'd1;
            tx_nxt     = frame_bit(cur_byte, tx_bit + 4'd1);
          end
        end else begin
          tx_baud_nxt = tx_baud + 12'd1;
        end
      end
      WAIT_RESP: begin
        tmo_cnt_nxt = tmo_cnt + 26'd1;
        if (rx_good) begin
          resp_nxt  = rx_shift;
          rdy_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign TX             = tx_q;
  assign host.busy      = (state != IDLE);
  assign host.cmd_cmplt = cmplt_q;
  assign host.resp_rdy  = rdy_q;
  assign host.resp      = resp_q;
  assign host.timeout   = tmo_q;

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm: a table of transactions plus hand-written
// reset, idle-traffic and mid-frame abort sequences.
module tb_remote_comm;
  localparam int          BAUD = 8;
  localparam logic [25:0] TMO  = 26'd500;
  localparam int          WIN  = 520;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    int          poke;
    bit          send_rx;
    logic [7:0]  rx_byte;
    logic        rx_stop;
    int          rx_delay;
    int          exp_rdy;
    int          exp_tmo;
    logic [7:0]  exp_resp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic rx;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[4];
  vec_t abort_vec;

  remote_comm_if bus();

  remote_comm #(.BAUD_DIV(BAUD), .RESP_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus.slave),
    .TX   (tx),
    .RX   (rx)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] c, input logic [15:0] d);
    bus.snd_cmd = s;
    bus.cmd     = c;
    bus.data    = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BAUD) step;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) step;
    end
    rx = stop;
    repeat (BAUD) step;
    rx = 1'b1;
  endtask

  // One full transaction: check the 240-cycle TX waveform, then watch the response window.
  task automatic runTxn(input vec_t v, input string tag);
    logic [7:0] exp_bytes [3];
    logic [9:0] frame;
    logic [7:0] got;
    logic       samp [240];
    int bad, not_busy, early;
    int rdy_cnt, tmo_cnt, tmo_at, cmplt_cnt, overlap, busy_at_evt;
    exp_bytes = '{v.cmd, v.data[15:8], v.data[7:0]};
    applyStimulus(1'b1, v.cmd, v.data);
    step;
    applyStimulus(1'b0, 8'h00, 16'h0000);
    not_busy = 0;
    early    = 0;
    for (int k = 0; k < 240; k++) begin
      if (k > 0) step;
      samp[k] = tx;
      if (bus.busy !== 1'b1) not_busy++;
      if ({bus.cmd_cmplt, bus.resp_rdy, bus.timeout} !== 3'b000) early++;
      bus.snd_cmd = (k == v.poke);
    end
    bus.snd_cmd = 1'b0;
    for (int j = 0; j < 3; j++) begin
      frame = {1'b1, exp_bytes[j], 1'b0};
      bad   = 0;
      got   = '0;
      for (int i = 0; i < 10; i++)
        for (int s = 0; s < BAUD; s++)
          if (samp[(j * 10 + i) * BAUD + s] !== frame[i]) bad++;
      for (int i = 0; i < 8; i++)
        got[i] = samp[(j * 10 + i + 1) * BAUD + BAUD / 2];
      checkOutput($sformatf("%s tx_byte%0d", tag, j), 32'(got), 32'(exp_bytes[j]));
      checkOutput($sformatf("%s tx_bit_samples%0d_wrong", tag, j), bad, 0);
    end
    checkOutput({tag, " busy_low_during_tx"}, not_busy, 0);
    checkOutput({tag, " pulse_during_tx"}, early, 0);
    step;
    checkOutput({tag, " cmd_cmplt_at_240"}, 32'(bus.cmd_cmplt), 32'd1);
    checkOutput({tag, " tx_idle_after_frames"}, 32'(tx), 32'd1);

    rdy_cnt = 0; tmo_cnt = 0; tmo_at = 0; cmplt_cnt = 0; overlap = 0; busy_at_evt = 0;
    fork
      begin
        if (v.send_rx) begin
          repeat (v.rx_delay) step;
          sendRx(v.rx_byte, v.rx_stop);
        end
      end
      begin
        for (int c = 1; c <= WIN; c++) begin
          step;
          if (bus.resp_rdy === 1'b1) rdy_cnt++;
          if (bus.timeout === 1'b1) begin
            tmo_cnt++;
            tmo_at = c;
          end
          if (bus.cmd_cmplt === 1'b1) cmplt_cnt++;
          if ((bus.resp_rdy === 1'b1 || bus.timeout === 1'b1) && bus.busy !== 1'b0) busy_at_evt++;
          if (bus.resp_rdy === 1'b1 && bus.timeout === 1'b1) overlap++;
        end
      end
    join
    checkOutput({tag, " resp_rdy_pulses"}, rdy_cnt, v.exp_rdy);
    checkOutput({tag, " timeout_pulses"}, tmo_cnt, v.exp_tmo);
    checkOutput({tag, " timeout_cycle"}, tmo_at, (v.exp_tmo != 0) ? 500 : 0);
    checkOutput({tag, " resp_value"}, 32'(bus.resp), 32'(v.exp_resp));
    checkOutput({tag, " busy_at_end_event"}, busy_at_evt, 0);
    checkOutput({tag, " extra_cmd_cmplt"}, cmplt_cnt, 0);
    checkOutput({tag, " pulse_overlap"}, overlap, 0);
    checkOutput({tag, " idle_after_window"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rdy_cnt;
    int busy_cnt;
    vecs[0] = '{8'h02, 16'h1234, -1,  1'b1, 8'hA5, 1'b1, 20,  1, 0, 8'hA5};
    vecs[1] = '{8'h5A, 16'hFFFF, 100, 1'b0, 8'h00, 1'b1, 0,   0, 1, 8'hA5};
    vecs[2] = '{8'h81, 16'h00FF, -1,  1'b1, 8'h3C, 1'b0, 20,  0, 1, 8'hA5};
    vecs[3] = '{8'hC3, 16'hA55A, -1,  1'b1, 8'h7E, 1'b1, 100, 1, 0, 8'h7E};
    abort_vec = '{8'h05, 16'h0000, -1, 1'b0, 8'h00, 1'b1, 0, 0, 1, 8'h00};

    rst = 1'b1;
    rx  = 1'b1;
    applyStimulus(1'b1, 8'h02, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      step;
      checkOutput($sformatf("reset%0d tx", i), 32'(tx), 32'd1);
      checkOutput($sformatf("reset%0d busy", i), 32'(bus.busy), 32'd0);
      checkOutput($sformatf("reset%0d resp", i), 32'(bus.resp), 32'h00);
      checkOutput($sformatf("reset%0d pulses", i),
                  32'({bus.cmd_cmplt, bus.resp_rdy, bus.timeout}), 32'd0);
    end
    applyStimulus(1'b0, 8'h00, 16'h0000);
    rst = 1'b0;
    repeat (3) step;
    checkOutput("post_reset tx", 32'(tx), 32'd1);
    checkOutput("post_reset busy", 32'(bus.busy), 32'd0);

    for (int n = 0; n < 4; n++)
      runTxn(vecs[n], $sformatf("vec%0d", n));

    // Good frame on RX while idle must be ignored.
    rdy_cnt  = 0;
    busy_cnt = 0;
    fork
      sendRx(8'h3C, 1'b1);
      begin
        for (int c = 0; c < 120; c++) begin
          step;
          if (bus.resp_rdy === 1'b1) rdy_cnt++;
          if (bus.busy !== 1'b0) busy_cnt++;
        end
      end
    join
    checkOutput("idle_rx resp_rdy_pulses", rdy_cnt, 0);
    checkOutput("idle_rx busy_cycles", busy_cnt, 0);
    checkOutput("idle_rx resp_value", 32'(bus.resp), 32'h7E);

    // Abort mid data bit 4 of byte 2.
    applyStimulus(1'b1, 8'hAA, 16'h5555);
    step;
    applyStimulus(1'b0, 8'h00, 16'h0000);
    repeat (122) step;
    rst = 1'b1;
    step;
    checkOutput("abort tx", 32'(tx), 32'd1);
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort resp", 32'(bus.resp), 32'h00);
    rst = 1'b0;
    repeat (BAUD * 2) begin
      step;
      if (tx !== 1'b1 || bus.busy !== 1'b0) busy_cnt++;
    end
    checkOutput("abort quiet_cycles", busy_cnt, 0);
    runTxn(abort_vec, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/remote_comm.md
Name: remote_comm

Overview:
- Ground-station end of the copter's wireless command link: the transmitter of the command frames that the copter's UART command receiver decodes, and the receiver of its 1-byte response.
- Accepts a command plus 16-bit data from the host/bench and serializes three bytes over UART 8N1: cmd, then data[15:8], then data[7:0].
- Then waits for the copter's response byte (for example the ack or the battery level), with a timeout.
- Used in the full-chip testbench and in the remote-controller FPGA image.

Parameters:
- BAUD_DIV, 2604, clk cycles per UART bit (50 MHz / 19200 baud); minimum 4.
- RESP_TIMEOUT, 26'd50_000_000, clk cycles allowed in WAIT_RESP before abandoning (1 s).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- snd_cmd  in  1  request to send; sampled only in IDLE.
- cmd  in  8  command byte.
- data  in  16  command data.
- TX  out  1  UART serial out to the copter RX line; idle high.
- RX  in  1  UART serial in from the copter TX line; asynchronous.
- busy  out  1  high while a transaction is in progress.
- cmd_cmplt  out  1  one-cycle pulse when the last stop bit of byte 3 ends.
- resp_rdy  out  1  one-cycle pulse when the response byte is captured.
- resp  out  8  last response byte; held until the next capture.
- timeout  out  1  one-cycle pulse when the response wait expires.

Behaviour:
- Reset: single clock, synchronous active-high reset. At a rising edge with rst=1:
  - TX=1, busy=0, cmd_cmplt=0, resp_rdy=0, resp=8'h00, timeout=0.
  - FSM=IDLE; all counters cleared; RX synchronizer flops set to 1.
  - Reset asserted mid-frame aborts immediately: TX is high from the next cycle and there is no partial stop bit.
- FSM states: IDLE, TX_CMD, TX_DH, TX_DL, WAIT_RESP.
- IDLE:
  - snd_cmd=1 latches cmd and data into shadow registers and moves to TX_CMD.
  - busy rises the cycle after acceptance.
- TX_CMD / TX_DH / TX_DL: each sends one 10-bit frame.
  - Frame: start bit 0, eight data bits LSB first, stop bit 1; each bit lasts exactly BAUD_DIV cycles.
  - The start bit of byte 1 appears on TX the cycle after the acceptance edge.
  - Frames are back-to-back with no idle gap, so the three bytes occupy 30*BAUD_DIV cycles.
  - When the last stop bit ends: cmd_cmplt pulses, the timeout counter clears, and the FSM moves to WAIT_RESP.
- TX output is registered; no glitches.
- RX path:
  - Two-flop synchronizer, then falling-edge detect to start a frame.
  - Start bit is re-sampled at BAUD_DIV/2; if it is high, it was a false start and the receiver returns to hunting.
  - Data bits are sampled every BAUD_DIV cycles from that point; the stop bit is sampled the same way.
  - Stop bit = 0 is a framing error: the byte is discarded and there is no pulse.
  - The receiver runs in all states. A good byte captured outside WAIT_RESP is discarded: resp is unchanged and there is no resp_rdy.
- WAIT_RESP:
  - Counter increments each cycle.
  - A good byte captured here: resp loaded, resp_rdy pulses on the same edge, return to IDLE.
  - Counter reaching RESP_TIMEOUT-1 with no byte: timeout pulses and the FSM returns to IDLE, so the pulse comes exactly RESP_TIMEOUT cycles after cmd_cmplt.
  - busy falls on the edge that leaves WAIT_RESP.
- Simultaneous events:
  - Byte completes on the same cycle as timeout expiry: the response wins; resp_rdy=1, timeout=0.
  - snd_cmd while busy, including on the cycle of resp_rdy or timeout: ignored, with no latching.
  - snd_cmd held high in IDLE: starts a new transaction every time the FSM returns to IDLE.
- Outputs cmd_cmplt, resp_rdy and timeout are mutually exclusive, and each is high for exactly one cycle.
- Widths: bit counters are 4 bits, the baud counter is 12 bits, and the timeout counter is 26 bits. No arithmetic on the payload.

Test Plan:
- Reset check: hold rst 3 cycles while driving snd_cmd=1 -> TX=1, busy=0, resp=8'h00 and all pulses 0 throughout; no frame starts.
- Framing (BAUD_DIV=8): cmd=8'h02, data=16'h1234 -> TX carries start,0,1,0,0,0,0,0,0,stop, then bytes 0x12 and 0x34, each bit 8 cycles; cmd_cmplt pulses at cycle 240 after acceptance; busy=1 throughout.
- Response: the bench sends 0xA5 on RX (BAUD_DIV=8) 20 cycles after cmd_cmplt -> a single resp_rdy pulse, resp=8'hA5, busy=0; timeout never asserts.
- Timeout (RESP_TIMEOUT=500): RX held high -> timeout pulse exactly 500 cycles after cmd_cmplt, busy=0, resp unchanged.
- Ignored traffic: snd_cmd pulsed during TX_DH, and a 0x3C frame sent on RX while IDLE -> no second transaction, no resp_rdy, resp stays unchanged; a frame with stop bit 0 during WAIT_RESP -> discarded, and timeout still fires.
- Abort: rst asserted mid-bit 4 of byte 2 -> TX=1 next cycle, busy=0; a following cmd=8'h05, data=16'h0000 transmits three clean frames.
